bullet_ctrl: RTL
================

# bullet_ctrl

Per-player shot controller that answers the game turn FSM's grant and drives its shot handshake. On a turn grant plus a fire press it launches a projectile, integrates ballistic motion once per frame, and detects a hit on the opposing tank, ground/edge exit or timeout. It then closes the turn with a one-frame stop pulse. Two instances exist (player 1 and player 2); their shoot/stop flags feed the turn FSM, and `hit` feeds the opponent's health logic.

## Interface
- DIR, 1 — launch direction: 1 = fire toward +x (player 1), 0 = toward −x (player 2)
- GRAV, 1 — added to vertical velocity each flight frame (pixels/frame²)
- GROUND_Y, 420 — ny ≥ GROUND_Y ends flight
- HIT_HALF_W, 8 / HIT_HALF_H, 6 — target hit-box half extents
- MAX_FRAMES, 255 — flight frames before forced stop
- frame_clk  in  1  frame clock, one edge per video frame
- Reset  in  1  **reset Reset, asynchronous, active-high; clock frame_clk**
- player_flag  in  1  turn grant from turn FSM
- fire  in  1  fire key (level)
- muzzle_x, muzzle_y  in  10  launch position
- vx_init, vy_init  in  8  unsigned launch speed magnitudes (horizontal, upward)
- target_x, target_y  in  10  opposing tank centre
- wind  in  4  signed wind (used only with WIND_EN)
- bull_shoot_flag  out  1  one-frame launch pulse
- bull_stop_flag  out  1  one-frame end-of-shot pulse
- hit  out  1  valid with bull_stop_flag; target struck
- bullet_visible  out  1  FLIGHT and 0 ≤ py ≤ 479
- bullet_x, bullet_y  out  10  low 10 bits of position

## Operation
- States: IDLE, LAUNCH, FLIGHT, DONE.
- IDLE → LAUNCH when player_flag=1 and fire rises (fire=1, fire_q=0) in the same frame; otherwise ignored. Fire held across a grant does not launch until released and re-pressed.
- LAUNCH: bull_shoot_flag=1; px=muzzle_x, py=muzzle_y, vx=DIR ? +vx_init : −vx_init, vy=−vy_init, frame count=0. Always → FLIGHT.
- FLIGHT, each frame: nx=px+vx, ny=py+vy; px←nx, py←ny, vy←vy+GRAV saturated to +127; count++.
- Stop checks use (nx,ny), priority: hit (|nx−target_x| ≤ HIT_HALF_W and |ny−target_y| ≤ HIT_HALF_H) > out (nx<0, nx>639, ny ≥ GROUND_Y) > timeout (count == MAX_FRAMES−1). Any stop condition → DONE, with hit latched. ny<0 keeps flying (not visible).
- DONE: bull_stop_flag=1, hit=latched value. Always → IDLE.
- player_flag deasserting during LAUNCH/FLIGHT does not abort the shot.
- Arithmetic: px/py signed 12-bit, vx/vy signed 8-bit, sign-extended before add.

## Timing
- Reset (any time, including mid-flight): state IDLE, all outputs 0, registers 0, fire_q 0.
- Fire edge sampled at edge k → LAUNCH at cycle k+1 (bull_shoot_flag high exactly one cycle).
- The first position update is visible at cycle k+2.
- The stop pulse occurs in the cycle after the FLIGHT cycle that met the condition. Minimum shot is 3 cycles: LAUNCH, 1×FLIGHT, DONE.
- hit is 0 in every cycle except DONE.
- Flags are registered Moore outputs, so the turn FSM sees each pulse on exactly one frame edge.

## Configuration
- WIND_EN defined: wind is sampled at LAUNCH. On every 8th FLIGHT frame (count[2:0]==7) vx ← vx + wind, saturated to ±127.
- WIND_EN undefined: wind port is present but ignored; vx is constant through flight.

## Structure
- The shared package `tank_pkg` holds the state enum `bullet_state_t` and the constants SCREEN_W=640 and SCREEN_H=480.
- One combinational sub-module, `bullet_collide`: takes (nx, ny, target, parameters) and returns hit/out flags. It is reused by the renderer for overlap tests.

## Test plan
- Defaults, muzzle (100,400), vx_init=5, vy_init=0, launch at L → positions (105,400),(110,401),(115,403),(120,406),(125,410),(130,415),(135,421). DONE at L+8, hit=0.
- Same shot, target (130,405) → hit at 5th flight frame (125,410). bull_stop_flag and hit high at L+6.
- GRAV=0, MAX_FRAMES=16, vx_init=vy_init=0 → position stays (100,400). DONE at L+17, hit=0.
- fire held high before player_flag rises → no launch. Release and re-press → launch next cycle.
- Reset asserted at L+3 → all outputs 0 immediately, IDLE. No stop pulse follows.
- WIND_EN, wind=−2, vx_init=5 → vx=3 after 8th flight frame.

Source files
------------

// File: rtl/tank_pkg.sv
// Shared tank-game package: bullet FSM states, screen geometry and a
// saturating signed 8-bit velocity add used by the shot controller.
package tank_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    FLIGHT = 2'd2,
    DONE   = 2'd3
  } bullet_state_t;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;

  // Velocities clamp symmetrically at +/-127 so they never flip sign on overflow.
  function automatic logic signed [7:0] sat_add8(input logic signed [7:0] a,
                                                 input logic signed [7:0] b);
    logic signed [8:0] s;
    s = {a[7], a} + {b[7], b};
    if (s > 9'sd127) return 8'sd127;
    else if (s < -9'sd127) return -8'sd127;
    return s[7:0];
  endfunction

endpackage

// File: rtl/bullet_ctrl_if.sv
// Shot handshake and geometry bundle between the turn FSM / renderer side
// (master) and one bullet_ctrl instance (slave).
interface bullet_ctrl_if;
  logic       player_flag;
  logic       fire;
  logic [9:0] muzzle_x;
  logic [9:0] muzzle_y;
  logic [7:0] vx_init;
  logic [7:0] vy_init;
  logic [9:0] target_x;
  logic [9:0] target_y;
  logic [3:0] wind;
  logic       bull_shoot_flag;
  logic       bull_stop_flag;
  logic       hit;
  logic       bullet_visible;
  logic [9:0] bullet_x;
  logic [9:0] bullet_y;

  modport master (
    output player_flag, fire, muzzle_x, muzzle_y, vx_init, vy_init,
           target_x, target_y, wind,
    input  bull_shoot_flag, bull_stop_flag, hit, bullet_visible, bullet_x, bullet_y
  );

  modport slave (
    input  player_flag, fire, muzzle_x, muzzle_y, vx_init, vy_init,
           target_x, target_y, wind,
    output bull_shoot_flag, bull_stop_flag, hit, bullet_visible, bullet_x, bullet_y
  );
endinterface

// File: rtl/bullet_collide.sv
// Combinational overlap test of a candidate bullet position against a target
// hit-box and the playfield edges / ground line. Also used by the renderer.
module bullet_collide
  import tank_pkg::*;
#(
  parameter int GROUND_Y   = 420,
  parameter int HIT_HALF_W = 8,
  parameter int HIT_HALF_H = 6
)(
  input  logic signed [11:0] nx_i,
  input  logic signed [11:0] ny_i,
  input  logic        [9:0]  target_x_i,
  input  logic        [9:0]  target_y_i,
  output logic               hit_o,
  output logic               out_o
);

  logic signed [12:0] dx, dy;
  logic        [12:0] adx, ady;

  // One extra bit keeps the difference of a 12-bit signed and 10-bit unsigned exact.
  always_comb begin
    dx    = {nx_i[11], nx_i} - $signed({3'b000, target_x_i});
    dy    = {ny_i[11], ny_i} - $signed({3'b000, target_y_i});
    adx   = dx[12] ? 13'(-dx) : 13'(dx);
    ady   = dy[12] ? 13'(-dy) : 13'(dy);
    hit_o = (adx <= 13'(HIT_HALF_W)) && (ady <= 13'(HIT_HALF_H));
    out_o = nx_i[11]
         || (nx_i > $signed(12'(SCREEN_W - 1)))
         || (ny_i >= $signed(12'(GROUND_Y)));
  end

endmodule

// File: rtl/bullet_ctrl.sv
// Per-player shot controller: launch on grant + fire edge, per-frame ballistic
// update, stop on hit / exit / timeout. Define WIND_EN to enable wind drift.
module bullet_ctrl
  import tank_pkg::*;
#(
  parameter bit DIR        = 1'b1,
  parameter int GRAV       = 1,
  parameter int GROUND_Y   = 420,
  parameter int HIT_HALF_W = 8,
  parameter int HIT_HALF_H = 6,
  parameter int MAX_FRAMES = 255
)(
  input logic          frame_clk,
  input logic          Reset,
  bullet_ctrl_if.slave bus
);

  bullet_state_t      state_q, state_d;
  logic               fire_q;
  logic signed [11:0] px_q, px_d, py_q, py_d, nx, ny;
  logic signed [7:0]  vx_q, vx_d, vy_q, vy_d;
  logic        [7:0]  count_q, count_d;
  logic               shoot_q, shoot_d, stop_q, stop_d, hit_q, hit_d, vis_q, vis_d;
  logic               coll_hit, coll_out, timeout;
`ifdef WIND_EN
  logic signed [3:0]  wind_q, wind_d;
`else
  logic               unused_wind;
  assign unused_wind = ^bus.wind;
`endif

  assign nx      = px_q + {{4{vx_q[7]}}, vx_q};
  assign ny      = py_q + {{4{vy_q[7]}}, vy_q};
  assign timeout = (count_q == 8'(MAX_FRAMES - 1));

  bullet_collide #(
    .GROUND_Y  (GROUND_Y),
    .HIT_HALF_W(HIT_HALF_W),
    .HIT_HALF_H(HIT_HALF_H)
  ) u_collide (
    .nx_i      (nx),
    .ny_i      (ny),
    .target_x_i(bus.target_x),
    .target_y_i(bus.target_y),
    .hit_o     (coll_hit),
    .out_o     (coll_out)
  );

  always_comb begin
    state_d = state_q;
    px_d    = px_q;
    py_d    = py_q;
    vx_d    = vx_q;
    vy_d    = vy_q;
    count_d = count_q;
    hit_d   = 1'b0;
`ifdef WIND_EN
    wind_d  = wind_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.player_flag && bus.fire && !fire_q) state_d = LAUNCH;
      end
      LAUNCH: begin
        px_d    = {2'b00, bus.muzzle_x};
        py_d    = {2'b00, bus.muzzle_y};
        vx_d    = DIR ? bus.vx_init : (8'd0 - bus.vx_init);
        vy_d    = 8'd0 - bus.vy_init;
        count_d = '0;
`ifdef WIND_EN
        wind_d  = bus.wind;
`endif
        state_d = FLIGHT;
      end
      FLIGHT: begin
        px_d    = nx;
        py_d    = ny;
        vy_d    = sat_add8(vy_q, 8'(GRAV));
        count_d = count_q + 8'd1;
`ifdef WIND_EN
        // Wind nudges vx after this frame's move, every eighth flight frame.
        if (count_q[2:0] == 3'd7) vx_d = sat_add8(vx_q, {{4{wind_q[3]}}, wind_q});
`endif
        if (coll_hit || coll_out || timeout) begin
          state_d = DONE;
          hit_d   = coll_hit;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Flags are registered from the next state so each pulse lines up with its state.
    shoot_d = (state_d == LAUNCH);
    stop_d  = (state_d == DONE);
    vis_d   = (state_d == FLIGHT) && !py_d[11] && (py_d <= $signed(12'(SCREEN_H - 1)));
  end

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      fire_q  <= 1'b0;
      px_q    <= '0;
      py_q    <= '0;
      vx_q    <= '0;
      vy_q    <= '0;
      count_q <= '0;
      shoot_q <= 1'b0;
      stop_q  <= 1'b0;
      hit_q   <= 1'b0;
      vis_q   <= 1'b0;
`ifdef WIND_EN
      wind_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      fire_q  <= bus.fire;
      px_q    <= px_d;
      py_q    <= py_d;
      vx_q    <= vx_d;
      vy_q    <= vy_d;
      count_q <= count_d;
      shoot_q <= shoot_d;
      stop_q  <= stop_d;
      hit_q   <= hit_d;
      vis_q   <= vis_d;
`ifdef WIND_EN
      wind_q  <= wind_d;
`endif
    end
  end

  assign bus.bull_shoot_flag = shoot_q;
  assign bus.bull_stop_flag  = stop_q;
  assign bus.hit             = hit_q;
  assign bus.bullet_visible  = vis_q;
  assign bus.bullet_x        = px_q[9:0];
  assign bus.bullet_y        = py_q[9:0];

endmodule
